seg_scan_mux: RTL and testbench

- Parametrised time-multiplexed 7-segment scan driver for the clock display path; successor to the fixed six-digit display driver.
- Generalises digit count, scan rate and blink period.
- Adds per-digit blink and blank masks, per-digit decimal points and optional hex decoding.
- Runs entirely on the system clock with a clock-enable tick; no derived clocks. Sits between the time/alarm counters and the board digit/segment pins.

---
 rtl/seg_scan_mux.sv | 119 +++++++++++
 tb/tb_seg_scan_mux.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scan driver. It advances one digit per prescaler tick
// and applies per-digit blank, blink and decimal-point control.
module seg_scan_mux #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 8,
  parameter int BLINK_MS = 400,
  parameter bit HEX_MODE = 1'b0
) (
  input  logic                  clk_100MHz,
  input  logic                  rst_time,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  blink_en,
  output logic [DIGITS-1:0]     bit_sel,
  output logic [6:0]            seg_sel,
  output logic                  dp_out,
  output logic                  frame_start
);

  localparam int DIV         = CLK_HZ / SCAN_HZ;
  localparam int BLINK_TICKS = BLINK_MS * SCAN_HZ / 1000;
  localparam int PW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW          = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW          = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PW-1:0]           r_pre;
  logic [IW-1:0]           r_idx;
  logic [BW-1:0]           r_bcnt;
  logic                    r_phase;
  logic [DIGITS-1:0]       r_bit_sel;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_fs;

  logic                    w_tick;
  logic [IW-1:0]           w_nxt_idx;
  logic [DIGITS-1:0][3:0]  w_nib;
  logic [DIGITS-1:0]       w_dark;
  logic [3:0]              w_val;
  logic [6:0]              w_seg;

  assign w_tick    = (r_pre == PW'(DIV - 1));
  assign w_nxt_idx = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
  assign w_nib     = digits_in;
  assign w_val     = w_nib[w_nxt_idx];

  // Blank wins over blink; blink only darkens during the odd half-period.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dark
    assign w_dark[k] = blank_mask[k] | (blink_en & blink_mask[k] & r_phase);
  end

  always_comb begin
    w_seg = 7'b1111111;
    case (w_val)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = HEX_MODE ? 7'b0001000 : 7'b1111111;
      4'hB: w_seg = HEX_MODE ? 7'b0000011 : 7'b1111111;
      4'hC: w_seg = HEX_MODE ? 7'b1000110 : 7'b1111111;
      4'hD: w_seg = HEX_MODE ? 7'b0100001 : 7'b1111111;
      4'hE: w_seg = HEX_MODE ? 7'b0000110 : 7'b1111111;
      4'hF: w_seg = HEX_MODE ? 7'b0001110 : 7'b1111111;
      default: w_seg = 7'b1111111;
    endcase
  end

  // Index resets to the last digit so the first tick lands on digit 0.
  always_ff @(posedge clk_100MHz or negedge rst_time) begin
    if (!rst_time) begin
      r_pre     <= '0;
      r_idx     <= IW'(DIGITS - 1);
      r_bcnt    <= '0;
      r_phase   <= 1'b0;
      r_bit_sel <= '1;
      r_seg     <= 7'b1111111;
      r_dp      <= 1'b1;
      r_fs      <= 1'b0;
    end else begin
      r_fs  <= 1'b0;
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_idx <= w_nxt_idx;
        r_fs  <= (w_nxt_idx == '0);
        if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
        if (w_dark[w_nxt_idx]) begin
          r_bit_sel <= '1;
          r_seg     <= 7'b1111111;
          r_dp      <= 1'b1;
        end else begin
          r_bit_sel <= ~(DIGITS'(1) << w_nxt_idx);
          r_seg     <= w_seg;
          r_dp      <= ~dp_in[w_nxt_idx];
        end
      end
    end
  end

  assign bit_sel     = r_bit_sel;
  assign seg_sel     = r_seg;
  assign dp_out      = r_dp;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: DIV=10, 4 digits, 4-tick blink half-period,
// with a decimal-only and a hex-decoding instance driven in parallel.
module tb_seg_scan_mux;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp, blinkm, blankm;
  logic        blen;
  logic [3:0]  bs0, bs1;
  logic [6:0]  sg0, sg1;
  logic        dpo0, dpo1, fs0, fs1;
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(.CLK_HZ(1000), .SCAN_HZ(100), .DIGITS(4), .BLINK_MS(40), .HEX_MODE(1'b0)) u_dec (
    .clk_100MHz(clk), .rst_time(rst_n), .digits_in(digits), .dp_in(dp),
    .blink_mask(blinkm), .blank_mask(blankm), .blink_en(blen),
    .bit_sel(bs0), .seg_sel(sg0), .dp_out(dpo0), .frame_start(fs0));

  seg_scan_mux #(.CLK_HZ(1000), .SCAN_HZ(100), .DIGITS(4), .BLINK_MS(40), .HEX_MODE(1'b1)) u_hex (
    .clk_100MHz(clk), .rst_time(rst_n), .digits_in(digits), .dp_in(dp),
    .blink_mask(blinkm), .blank_mask(blankm), .blink_en(blen),
    .bit_sel(bs1), .seg_sel(sg1), .dp_out(dpo1), .frame_start(fs1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check both instances in one slot; s0/s1 are the decimal/hex segment patterns.
  task automatic slot(input string tag, input logic [3:0] bs, input logic [6:0] s0,
                      input logic [6:0] s1, input logic d);
    chk({tag, ".bit0"}, 32'(bs0), 32'(bs));
    chk({tag, ".seg0"}, 32'(sg0), 32'(s0));
    chk({tag, ".dp0"},  32'(dpo0), 32'(d));
    chk({tag, ".bit1"}, 32'(bs1), 32'(bs));
    chk({tag, ".seg1"}, 32'(sg1), 32'(s1));
  endtask

  task automatic next_tick();
    repeat (10) @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S9 = 7'b0010000, SB = 7'b0000011, SX = 7'b1111111;

  initial begin
    rst_n = 1'b0; digits = 16'h9210; dp = 4'b0100;
    blinkm = 4'b0000; blankm = 4'b0000; blen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    slot("rst", 4'hF, SX, SX, 1'b1);
    chk("rst.fs", 32'(fs0), 32'd0);

    // Release, then nine edges still dark, tenth edge drives digit 0.
    @(negedge clk); rst_n = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_tick.bit", 32'(bs0), 32'hF);
    chk("pre_tick.fs", 32'(fs0), 32'd0);
    @(posedge clk); #1;
    slot("t1.d0", 4'b1110, S0, S0, 1'b1);
    chk("t1.fs", 32'(fs0), 32'd1);
    next_tick();
    slot("t2.d1", 4'b1101, S1, S1, 1'b1);
    chk("t2.fs", 32'(fs0), 32'd0);
    next_tick();
    slot("t3.d2", 4'b1011, S2, S2, 1'b0);
    next_tick();
    slot("t4.d3", 4'b0111, S9, S9, 1'b1);
    next_tick();
    slot("t5.d0", 4'b1110, S0, S0, 1'b1);
    chk("t5.fs", 32'(fs1), 32'd1);
    @(posedge clk); #1;
    chk("t5.fs_clr", 32'(fs0), 32'd0);
    chk("t5.hold", 32'(bs0), 32'hE);

    // Hex nibble on digit 0.
    digits = 16'h921B;
    repeat (9) @(posedge clk); #1;   // tick 6
    next_tick(); next_tick(); next_tick();
    slot("t9.hex", 4'b1110, SX, SB, 1'b1);

    // Blink digits 0/1; phase is dark on ticks 13-16 and 21-24.
    blen = 1'b1; blinkm = 4'b0011;
    next_tick(); slot("t10.d1", 4'b1101, S1, S1, 1'b1);
    next_tick(); slot("t11.d2", 4'b1011, S2, S2, 1'b0);
    next_tick(); slot("t12.d3", 4'b0111, S9, S9, 1'b1);
    next_tick(); slot("t13.d0dark", 4'hF, SX, SX, 1'b1);
    next_tick(); slot("t14.d1dark", 4'hF, SX, SX, 1'b1);
    next_tick(); slot("t15.d2", 4'b1011, S2, S2, 1'b0);
    next_tick(); slot("t16.d3", 4'b0111, S9, S9, 1'b1);
    next_tick(); slot("t17.d0vis", 4'b1110, SX, SB, 1'b1);
    next_tick(); next_tick(); next_tick();
    next_tick(); slot("t21.d0dark", 4'hF, SX, SX, 1'b1);
    blen = 1'b0;
    next_tick(); slot("t22.d1lit", 4'b1101, S1, S1, 1'b1);
    next_tick(); next_tick();
    next_tick(); slot("t25.d0lit", 4'b1110, SX, SB, 1'b1);

    // Blank digit 3 even with its dp requested.
    blankm = 4'b1000; dp = 4'b1100;
    next_tick();
    next_tick(); slot("t27.d2", 4'b1011, S2, S2, 1'b0);
    next_tick(); slot("t28.d3blank", 4'hF, SX, SX, 1'b1);
    next_tick(); next_tick();
    next_tick(); slot("t31.d2", 4'b1011, S2, S2, 1'b0);

    // Asynchronous reset in the digit-2 slot, between clock edges.
    #2; rst_n = 1'b0; #1;
    slot("arst", 4'hF, SX, SX, 1'b1);
    blen = 1'b1; blinkm = 4'b0011;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (9) @(posedge clk); #1;
    chk("r.pre_tick", 32'(bs0), 32'hF);
    @(posedge clk); #1;
    slot("r1.d0", 4'b1110, SX, SB, 1'b1);
    chk("r1.fs", 32'(fs0), 32'd1);
    next_tick(); slot("r2.d1", 4'b1101, S1, S1, 1'b1);
    next_tick(); slot("r3.d2", 4'b1011, S2, S2, 1'b0);
    next_tick(); slot("r4.d3blank", 4'hF, SX, SX, 1'b1);
    next_tick(); slot("r5.d0dark", 4'hF, SX, SX, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
